// File: rtl/fifo_stream_drain_if.sv
// FIFO read-port and valid/ready stream signals for fifo_stream_drain.
interface fifo_stream_drain_if #(
   parameter int unsigned width = 8
);
   // FIFO show-ahead read port
   logic             fifo_empty;
   logic [width-1:0] fifo_read_data;
   logic             fifo_pop;

   // Outgoing stream
   logic             out_valid;
   logic             out_ready;
   logic [width-1:0] out_data;
   logic             out_last;

   // Drain side: pops the FIFO and sources the stream
   modport master (
      input  fifo_empty, fifo_read_data, out_ready,
      output fifo_pop, out_valid, out_data, out_last
   );

   // Environment side: FIFO plus stream consumer
   modport slave (
      output fifo_empty, fifo_read_data, out_ready,
      input  fifo_pop, out_valid, out_data, out_last
   );
endinterface

// File: rtl/fifo_stream_drain.sv
// Drains a show-ahead FIFO into a valid/ready stream through a 2-entry
// main/skid slice and frames the beats into fixed-length bursts.
module fifo_stream_drain #(
   parameter int unsigned width     = 8,
   parameter int unsigned burst_len = 4
) (
   input  logic                clk,
   input  logic                rst,
   fifo_stream_drain_if.master bus,
   output logic                idle
);

   localparam int unsigned       beat_w   = (burst_len > 1) ? $clog2(burst_len) : 1;
   localparam logic [beat_w-1:0] beat_max = beat_w'(burst_len - 1);

   // Slice occupancy: number of words held in main (and skid when full)
   typedef enum logic [1:0] {
      st_empty = 2'd0,
      st_one   = 2'd1,
      st_two   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [width-1:0]  r_main;
   logic [width-1:0]  r_skid;
   logic [beat_w-1:0] r_beat;
   logic [beat_w-1:0] w_beat_nxt;

   logic w_valid;
   logic w_pop;
   logic w_fire;
   logic w_beat_last;
   logic w_load_main;
   logic w_load_skid;
   logic w_shift_skid;

   // Pop never looks at out_ready, only at registered occupancy
   assign w_valid     = (r_state != st_empty);
   assign w_pop       = ~bus.fifo_empty & (r_state != st_two) & rst;
   assign w_fire      = w_valid & bus.out_ready;
   assign w_beat_last = (r_beat == beat_max);

   // Occupancy state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= st_empty;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next occupancy and data-register load selects
   always_comb begin
      w_state_nxt  = r_state;
      w_load_main  = 1'b0;
      w_load_skid  = 1'b0;
      w_shift_skid = 1'b0;
      case (r_state)
         st_empty: begin
            if (w_pop) begin
               w_load_main = 1'b1;
               w_state_nxt = st_one;
            end
         end
         st_one: begin
            if (w_pop && !w_fire) begin
               w_load_skid = 1'b1;
               w_state_nxt = st_two;
            end else if (w_pop && w_fire) begin
               w_load_main = 1'b1;
            end else if (w_fire) begin
               w_state_nxt = st_empty;
            end
         end
         st_two: begin
            if (w_fire) begin
               w_shift_skid = 1'b1;
               w_state_nxt  = st_one;
            end
         end
         default: begin
            w_state_nxt = st_empty;
         end
      endcase
   end

   // Data registers carry no reset; occupancy alone says what is valid
   always_ff @(posedge clk) begin
      if (w_load_main) begin
         r_main <= bus.fifo_read_data;
      end else if (w_shift_skid) begin
         r_main <= r_skid;
      end
      if (w_load_skid) begin
         r_skid <= bus.fifo_read_data;
      end
   end

   // Burst position advances on each accepted beat and wraps at the last one
   always_comb begin
      w_beat_nxt = r_beat;
      if (w_fire) begin
         w_beat_nxt = w_beat_last ? '0 : r_beat + beat_w'(1);
      end
   end

   // Burst position register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_beat <= '0;
      end else begin
         r_beat <= w_beat_nxt;
      end
   end

   assign bus.fifo_pop  = w_pop;
   assign bus.out_valid = w_valid;
   assign bus.out_data  = r_main;
   assign bus.out_last  = w_valid & w_beat_last;
   assign idle          = (r_state == st_empty) & bus.fifo_empty;

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: queue-based FIFO model feeding the DUT, a
// scoreboard of pushed words checked against delivered beats, and a small
// occupancy/burst reference model checked every cycle.
module tb_fifo_stream_drain;

   localparam int unsigned width     = 8;
   localparam int unsigned burst_len = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic idle;

   fifo_stream_drain_if #(.width(width)) bus ();

   fifo_stream_drain #(.width(width), .burst_len(burst_len)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .idle (idle)
   );

   always #5 clk = ~clk;

   logic [7:0] fq[$];          // FIFO contents, head at index 0
   logic [7:0] sb[$];          // words expected on the stream, in order
   logic [7:0] got_words[$];   // words actually delivered
   logic [7:0] last_words[$];  // delivered words flagged out_last
   int m_cnt  = 0;
   int m_beat = 0;
   int total  = 0;
   int bad    = 0;

   task automatic push(input logic [7:0] w);
      fq.push_back(w);
      sb.push_back(w);
   endtask

   // Present the FIFO head and let combinational outputs settle
   task automatic settle();
      bus.fifo_empty     = (fq.size() == 0);
      bus.fifo_read_data = (fq.size() == 0) ? 8'hxx : fq[0];
      #1;
   endtask

   // One clock: check outputs against the model, then advance model and FIFO
   task automatic step();
      logic       pop_e, fire_e, last_e, idle_e;
      logic [7:0] exp_w, tmp;
      settle();
      pop_e  = rst && (fq.size() != 0) && (m_cnt != 2);
      fire_e = rst && (m_cnt != 0) && bus.out_ready;
      last_e = (m_cnt != 0) && (m_beat == burst_len - 1);
      idle_e = (m_cnt == 0) && (fq.size() == 0);
      total++;
      if (bus.out_valid !== (m_cnt != 0)) begin
         bad++;
         $display("FAIL out_valid: got %b want %b (cnt=%0d)", bus.out_valid, (m_cnt != 0), m_cnt);
      end
      total++;
      if (bus.fifo_pop !== pop_e) begin
         bad++;
         $display("FAIL fifo_pop: got %b want %b (cnt=%0d rst=%b)", bus.fifo_pop, pop_e, m_cnt, rst);
      end
      total++;
      if (idle !== idle_e) begin
         bad++;
         $display("FAIL idle: got %b want %b", idle, idle_e);
      end
      total++;
      if (bus.out_last !== last_e) begin
         bad++;
         $display("FAIL out_last: got %b want %b (beat=%0d)", bus.out_last, last_e, m_beat);
      end
      if (fire_e) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL extra_beat: got %h want none", bus.out_data);
         end else begin
            exp_w = sb.pop_front();
            if (bus.out_data !== exp_w) begin
               bad++;
               $display("FAIL out_data: got %h want %h", bus.out_data, exp_w);
            end
         end
         got_words.push_back(bus.out_data);
         if (bus.out_last === 1'b1) last_words.push_back(bus.out_data);
         m_beat = (m_beat == burst_len - 1) ? 0 : m_beat + 1;
      end
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < m_cnt; i++) tmp = sb.pop_front();
         m_cnt  = 0;
         m_beat = 0;
      end else begin
         if (pop_e) tmp = fq.pop_front();
         case (m_cnt)
            0: if (pop_e) m_cnt = 1;
            1: begin
               if (pop_e && !fire_e) m_cnt = 2;
               else if (!pop_e && fire_e) m_cnt = 0;
            end
            default: if (fire_e) m_cnt = 1;
         endcase
      end
      @(negedge clk);
   endtask

   task automatic run_until_empty(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) step();
   endtask

   task automatic clear_log();
      got_words.delete();
      last_words.delete();
   endtask

   task automatic test_reset();
      clear_log();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
      for (int i = 0; i < 2; i++) begin
         settle();
         total++;
         if (bus.fifo_pop !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got pop=%b valid=%b last=%b want 0 0 0",
                     bus.fifo_pop, bus.out_valid, bus.out_last);
         end
         step();
      end
      rst = 1'b1;
      settle();
      total++;
      if (bus.fifo_pop !== 1'b1) begin
         bad++;
         $display("FAIL first_pop: got %b want 1", bus.fifo_pop);
      end
      step();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b0 || bus.out_data !== 8'hA0) begin
         bad++;
         $display("FAIL first_beat: got valid=%b last=%b data=%h want 1 0 a0",
                  bus.out_valid, bus.out_last, bus.out_data);
      end
      run_until_empty(50);
      total++;
      if (sb.size() != 0 || got_words.size() != 4) begin
         bad++;
         $display("FAIL reset_drain: got left=%0d delivered=%0d want 0 4", sb.size(), got_words.size());
      end
   endtask

   task automatic test_streaming();
      int n;
      clear_log();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         step();
         n++;
      end
      total++;
      if (n != 9) begin
         bad++;
         $display("FAIL stream_cycles: got %0d want 9", n);
      end
      total++;
      if (got_words.size() != 8) begin
         bad++;
         $display("FAIL stream_count: got %0d want 8", got_words.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (got_words[i] !== 8'h10 + 8'(i)) begin
               bad++;
               $display("FAIL stream_order[%0d]: got %h want %h", i, got_words[i], 8'h10 + 8'(i));
            end
         end
      end
      total++;
      if (last_words.size() != 2 || last_words[0] !== 8'h13 || last_words[1] !== 8'h17) begin
         bad++;
         $display("FAIL stream_last: got %0d flagged words want 13,17", last_words.size());
      end
      settle();
      total++;
      if (idle !== 1'b1) begin
         bad++;
         $display("FAIL stream_idle: got %b want 1", idle);
      end
   endtask

   task automatic test_backpressure();
      clear_log();
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      for (int c = 1; c <= 6; c++) begin
         bus.out_ready = (c < 2);
         if (c >= 3) begin
            settle();
            total++;
            if (bus.fifo_pop !== 1'b0) begin
               bad++;
               $display("FAIL bp_pop_when_full: got %b want 0", bus.fifo_pop);
            end
         end
         step();
         if (c >= 2) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10) begin
               bad++;
               $display("FAIL bp_hold: got valid=%b data=%h want 1 10", bus.out_valid, bus.out_data);
            end
         end
      end
      bus.out_ready = 1'b1;
      run_until_empty(50);
      total++;
      if (got_words.size() != 8) begin
         bad++;
         $display("FAIL bp_count: got %0d want 8", got_words.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (got_words[i] !== 8'h10 + 8'(i)) begin
               bad++;
               $display("FAIL bp_order[%0d]: got %h want %h", i, got_words[i], 8'h10 + 8'(i));
            end
         end
      end
   endtask

   task automatic test_random_ready();
      int next;
      int cyc;
      clear_log();
      next = 0;
      cyc  = 0;
      while ((next < 64 || sb.size() != 0) && cyc < 3000) begin
         if (next < 64 && $urandom_range(1, 0) == 1) begin
            push(8'(next));
            next++;
         end
         bus.out_ready = ($urandom_range(1, 0) == 1);
         step();
         cyc++;
      end
      total++;
      if (got_words.size() != 64) begin
         bad++;
         $display("FAIL rand_count: got %0d want 64", got_words.size());
      end else begin
         for (int i = 0; i < 64; i++) begin
            if (got_words[i] !== 8'(i)) begin
               bad++;
               $display("FAIL rand_order[%0d]: got %h want %h", i, got_words[i], 8'(i));
            end
         end
      end
      total++;
      if (last_words.size() != 16) begin
         bad++;
         $display("FAIL rand_last_count: got %0d want 16", last_words.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (last_words[i] !== 8'(4 * i + 3)) begin
               bad++;
               $display("FAIL rand_last[%0d]: got %h want %h", i, last_words[i], 8'(4 * i + 3));
            end
         end
      end
   endtask

   task automatic test_underflow();
      clear_log();
      bus.out_ready = 1'b1;
      push(8'h20);
      push(8'h21);
      for (int i = 0; i < 5; i++) step();
      total++;
      if (bus.out_valid !== 1'b0 || got_words.size() != 2) begin
         bad++;
         $display("FAIL uf_gap: got valid=%b delivered=%0d want 0 2", bus.out_valid, got_words.size());
      end
      push(8'h22);
      push(8'h23);
      run_until_empty(50);
      total++;
      if (last_words.size() != 1 || last_words[0] !== 8'h23) begin
         bad++;
         $display("FAIL uf_last: got %0d flagged words want only 23", last_words.size());
      end
   endtask

   task automatic test_reset_mid_burst();
      clear_log();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
      for (int i = 0; i < 3; i++) step();
      bus.out_ready = 1'b0;
      step();
      total++;
      if (got_words.size() != 2 || m_cnt != 2) begin
         bad++;
         $display("FAIL mid_setup: got delivered=%0d cnt=%0d want 2 2", got_words.size(), m_cnt);
      end
      rst = 1'b0;
      step();
      rst = 1'b1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: got valid=%b last=%b want 0 0", bus.out_valid, bus.out_last);
      end
      clear_log();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
      run_until_empty(50);
      total++;
      if (got_words.size() != 4 || last_words.size() != 1 || last_words[0] !== 8'h43) begin
         bad++;
         $display("FAIL mid_new_burst: got delivered=%0d flagged=%0d want 4 1 (on 43)",
                  got_words.size(), last_words.size());
      end
   endtask

   initial begin
      bus.out_ready      = 1'b0;
      bus.fifo_empty     = 1'b1;
      bus.fifo_read_data = 8'h00;
      @(negedge clk);
      test_reset();
      test_streaming();
      test_backpressure();
      test_random_ready();
      test_underflow();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion want finish before 500000");
      $fatal(1);
   end

endmodule
